script_loader: RTL and testbench
================================

# script_loader

Upstream feeder for the automatic script executor. Receives script bytes from the UART receive path while loading is enabled and stores them in a 256-byte buffer. Once loading closes cleanly, it serves the 16-bit instruction word addressed by the executor's `pc`. Outside a valid loaded script, it serves the end-game opcode so the executor always terminates safely.

## Interface
Parameters:
- `DEPTH`, 256: script buffer size in bytes; address width is 8.
- `END_WORD`, 16'h0014: word served when no valid script word exists (opcode field `[4:0]` = 5'b10100, end game).

Ports:
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `load_en`  in  1  load mode request (board switch, already synchronised); level-sensitive, edges detected internally.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe qualifying `rx_data`.
- `pc`  in  8  executor byte address; the word spans bytes `pc` and `pc+1`.
- `script`  out  16  `{mem[pc+1], mem[pc]}`, registered; reset value `END_WORD`.
- `script_len`  out  9  bytes accepted in the current or last load, 0..256; reset 0.
- `checksum`  out  8  mod-256 sum of bytes accepted; reset 0.
- `loaded`  out  1  high only in READY; reset 0.
- `load_err`  out  1  high only in ERR; reset 0.
- `busy`  out  1  high only in LOAD; reset 0.

## Operation
State machine: IDLE, LOAD, READY, ERR. Reset state is IDLE.

Rising edge of `load_en` (0 to 1 between consecutive cycles):
- From IDLE, READY or ERR, go to LOAD.
- Clear `script_len` and `checksum`.

In LOAD, each `rx_valid` cycle does the following:
- Write `rx_data` to `mem[script_len[7:0]]`.
- `script_len` += 1; `checksum` += `rx_data` (8-bit wrap).
- If `rx_valid` arrives with `script_len == 256`, do not write, go to ERR, and hold `script_len` at 256.

Falling edge of `load_en` while in LOAD:
- Go to READY if `script_len` is nonzero and even.
- Otherwise (empty or odd length, i.e. a partial instruction) go to ERR.

Other `rx_valid` handling:
- Ignored in IDLE, READY and ERR; no write and no counter change.

Read path, registered every cycle:
- In READY with `{1'b0,pc} + 1 < script_len` (9-bit compare): `script <= {mem[pc+1], mem[pc]}`.
- Otherwise: `script <= END_WORD`. This covers pc=255 (pc+1 wraps, treated as out of range), pc at or past the end, any non-READY state, and odd trailing bytes.

Memory contents are not cleared by reset; the state gate makes stale data unreadable.

## Timing
- Read latency: `script` reflects the `pc` sampled one cycle earlier. The executor holds `pc` for at least 2 cycles after it changes before consuming `script`.
- Write latency: a byte accepted at edge N is readable from edge N+1, once in READY.
- `rx_valid` in the same cycle as the `load_en` falling edge: the byte is accepted first, then the length check uses the updated `script_len`.
- `rx_valid` in the same cycle as the `load_en` rising edge: ignored, because the state is not yet LOAD.
- Back-to-back `rx_valid` on every cycle: all bytes are accepted with no stall.
- `rst` asserted mid-load:
  - Immediately go to IDLE and zero all counters.
  - `script` becomes `END_WORD` asynchronously.
  - Status outputs clear.
- Status outputs are decoded from the registered state, so they are glitch-free.

## Structure
Shared package `kitchen_pkg` holds:
- the state enum `loader_state_t`;
- `END_WORD`;
- the opcode field constants already used by the executor (end, start, wait, wait-until), so loader and executor agree on encodings.

One natural sub-module, `script_ram`:
- 256x8, one synchronous write port;
- two read ports (addresses `pc` and `pc+1`) feeding the output register.

Edge detection for `load_en` and the FSM stay in `script_loader`.

## Test plan
- Load `0C 00 14 00`, drop `load_en`, pc=0 then 2: `script` = 16'h000C then 16'h0014; `script_len`=4; `checksum`=8'h20; `loaded`=1.
- Load 3 bytes then drop `load_en`: `load_err`=1, `script_len`=3; `script` = `END_WORD` for every pc.
- Stream 257 bytes without pause: the 257th causes ERR, `script_len`=256, and `mem[0]` is unchanged from the first byte.
- READY with 256 bytes, pc=254: the stored word. pc=255: `END_WORD`, wrap not served.
- Assert `rst` after 10 bytes of a load: next cycle all outputs at reset values. A new load of `0C 00` then reads 16'h000C at pc=0.
- `rx_valid` coincident with the `load_en` fall, as the 2nd byte: accepted, READY, `script_len`=2. A stray `rx_valid` in READY changes nothing.

Source files
------------

// File: rtl/kitchen_pkg.sv
// Shared encodings for the script loader and executor.
// State enum, executor opcode fields and the end-game word.
package kitchen_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_ERR
  } loader_state_t;

  localparam logic [4:0] OP_START      = 5'b01100;
  localparam logic [4:0] OP_WAIT       = 5'b01101;
  localparam logic [4:0] OP_WAIT_UNTIL = 5'b01110;
  localparam logic [4:0] OP_END        = 5'b10100;

  localparam logic [15:0] END_WORD = {11'd0, OP_END};

endpackage

// File: rtl/script_ram.sv
// Script byte store: one synchronous write port and two
// asynchronous read ports (rdata_a/rdata_b) for pc and pc+1.
module script_ram #(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [7:0]    rdata_a,
  output logic [7:0]    rdata_b
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/script_loader.sv
// Loads script bytes from UART rx into a buffer and serves the
// 16-bit word at pc; ports: load_en/rx_*/pc in, script/status out.
module script_loader #(
  parameter int          DEPTH    = 256,
  parameter logic [15:0] END_WORD = kitchen_pkg::END_WORD,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic [AW-1:0] pc,
  output logic [15:0]   script,
  output logic [AW:0]   script_len,
  output logic [7:0]    checksum,
  output logic          loaded,
  output logic          load_err,
  output logic          busy
);

  import kitchen_pkg::*;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  loader_state_t state, state_nx;

  logic          load_q;
  logic          rise;
  logic          fall;
  logic          take;
  logic          ovf;
  logic [AW:0]   len_inc;
  logic [AW:0]   pc_end;
  logic [AW-1:0] pc_hi;
  logic          hit;
  logic [7:0]    rd_lo;
  logic [7:0]    rd_hi;

  assign rise = load_en & ~load_q;
  assign fall = ~load_en & load_q;

  assign take = (state == S_LOAD) && rx_valid
             && (script_len != FULL);
  assign ovf  = (state == S_LOAD) && rx_valid
             && (script_len == FULL);

  // length after this cycle's byte, so a byte coincident
  // with the falling edge counts toward the even check
  assign len_inc = script_len + {{AW{1'b0}}, take};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_q <= 1'b0;
      state  <= S_IDLE;
    end else begin
      load_q <= load_en;
      state  <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (rise) begin
      state_nx = S_LOAD;
    end else if (state == S_LOAD) begin
      if (ovf)
        state_nx = S_ERR;
      else if (fall)
        state_nx = (len_inc != '0 && !len_inc[0])
                 ? S_READY : S_ERR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      script_len <= '0;
      checksum   <= '0;
    end else if (rise) begin
      script_len <= '0;
      checksum   <= '0;
    end else if (take) begin
      script_len <= len_inc;
      checksum   <= checksum + rx_data;
    end
  end

  script_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we      (take),
    .waddr   (script_len[AW-1:0]),
    .wdata   (rx_data),
    .raddr_a (pc),
    .raddr_b (pc_hi),
    .rdata_a (rd_lo),
    .rdata_b (rd_hi)
  );

  // pc+1 wraps in the address but not in the 9-bit
  // compare, so pc=255 never serves {mem[0],mem[255]}
  assign pc_hi  = pc + {{(AW-1){1'b0}}, 1'b1};
  assign pc_end = {1'b0, pc} + {{AW{1'b0}}, 1'b1};
  assign hit    = (state == S_READY)
               && (pc_end < script_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      script <= END_WORD;
    else
      script <= hit ? {rd_hi, rd_lo} : END_WORD;
  end

  assign busy     = (state == S_LOAD);
  assign loaded   = (state == S_READY);
  assign load_err = (state == S_ERR);

endmodule

// File: tb/tb_script_loader.sv
// Directed bench for script_loader.
// Drives #1 after posedge and samples there too.
module tb_script_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  pc;
  logic [15:0] script;
  logic [8:0]  script_len;
  logic [7:0]  checksum;
  logic        loaded;
  logic        load_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] ENDW = 16'h0014;

  script_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_en    (load_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .pc         (pc),
    .script     (script),
    .script_len (script_len),
    .checksum   (checksum),
    .loaded     (loaded),
    .load_err   (load_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    pc = a;
    tick();
    tick();
  endtask

  task automatic start_load();
    load_en = 1'b1;
    tick();
  endtask

  task automatic end_load();
    load_en = 1'b0;
    tick();
  endtask

  initial begin
    rst      = 1'b0;
    load_en  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    pc       = 8'h00;
    tick();
    tick();
    chk("rst_script", script, ENDW);
    chk("rst_len", script_len, 0);
    chk("rst_cks", checksum, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_err", load_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick();

    // basic 4-byte load
    start_load();
    chk("t1_busy", busy, 1);
    send(8'h0C);
    send(8'h00);
    send(8'h14);
    send(8'h00);
    end_load();
    chk("t1_loaded", loaded, 1);
    chk("t1_len", script_len, 4);
    chk("t1_cks", checksum, 8'h20);
    rd(8'd0);
    chk("t1_pc0", script, 16'h000C);
    rd(8'd1);
    chk("t1_pc1", script, 16'h1400);
    rd(8'd2);
    chk("t1_pc2", script, 16'h0014);
    rd(8'd3);
    chk("t1_pc3", script, ENDW);

    // odd length
    start_load();
    send(8'h01);
    send(8'h02);
    send(8'h03);
    end_load();
    chk("t2_err", load_err, 1);
    chk("t2_loaded", loaded, 0);
    chk("t2_len", script_len, 3);
    for (int i = 0; i < 4; i++) begin
      rd(8'(i));
      chk("t2_script", script, ENDW);
    end

    // full 256-byte load, boundary reads
    start_load();
    for (int i = 0; i < 256; i++) begin
      rx_data  = 8'(i);
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    end_load();
    chk("t3_loaded", loaded, 1);
    chk("t3_len", script_len, 256);
    chk("t3_cks", checksum, 8'h80);
    rd(8'd254);
    chk("t3_pc254", script, 16'hFFFE);
    rd(8'd255);
    chk("t3_pc255", script, ENDW);
    rd(8'd0);
    chk("t3_pc0", script, 16'h0100);

    // 257 bytes back-to-back: overflow
    start_load();
    for (int i = 0; i < 257; i++) begin
      rx_data  = (i == 256) ? 8'h5A : 8'(i);
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    chk("t4_err", load_err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_len", script_len, 256);
    chk("t4_cks", checksum, 8'h80);
    chk("t4_mem0", dut.u_ram.mem[0], 8'h00);
    end_load();
    chk("t4_err_hold", load_err, 1);
    rd(8'd0);
    chk("t4_script", script, ENDW);

    // reset mid-load
    start_load();
    for (int i = 0; i < 10; i++) send(8'(i + 1));
    chk("t5_len10", script_len, 10);
    rst     = 1'b0;
    load_en = 1'b0;
    #1;
    chk("t5_async", script, ENDW);
    tick();
    chk("t5_script", script, ENDW);
    chk("t5_len", script_len, 0);
    chk("t5_cks", checksum, 0);
    chk("t5_busy", busy, 0);
    chk("t5_loaded", loaded, 0);
    chk("t5_err", load_err, 0);
    rst = 1'b1;
    tick();
    start_load();
    send(8'h0C);
    send(8'h00);
    end_load();
    chk("t5_loaded2", loaded, 1);
    rd(8'd0);
    chk("t5_pc0", script, 16'h000C);

    // rx on rising edge ignored; rx on falling
    // edge accepted; stray rx in READY ignored
    load_en  = 1'b1;
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("t6_rise_len", script_len, 0);
    chk("t6_rise_busy", busy, 1);
    send(8'h34);
    rx_data  = 8'h12;
    rx_valid = 1'b1;
    load_en  = 1'b0;
    tick();
    rx_valid = 1'b0;
    chk("t6_loaded", loaded, 1);
    chk("t6_len", script_len, 2);
    chk("t6_cks", checksum, 8'h46);
    rd(8'd0);
    chk("t6_pc0", script, 16'h1234);
    send(8'hFF);
    tick();
    chk("t6_stray_len", script_len, 2);
    chk("t6_stray_cks", checksum, 8'h46);
    chk("t6_stray_scr", script, 16'h1234);
    chk("t6_stray_rdy", loaded, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
